serial_frame_rx: RTL and testbench
==================================

// Module: serial_frame_rx
// PURPOSE
//  Serial frame receiver: samples an asynchronous serial line (idle high) through a
//  2-stage D flip-flop synchronizer and deserializes start/data/parity/stop frames.
//  Presents each word in a holding register with a valid/ack handshake.
//  Consumer-side neighbour of the DFF stage: it turns a sampled bit stream into parallel words.
// PARAMETERS
//  DATA_W        8  data bits per frame, sent LSB first
//  CLKS_PER_BIT  4  clk cycles per serial bit; legal range >= 4. HALF = CLKS_PER_BIT/2 (integer division)
//  PARITY_EN     1  1: one even-parity bit after the data bits. 0: no parity bit, parity_err held 0
// PORTS
//  clk         in   1       rising-edge clock
//  rst_n       in   1       asynchronous active-low reset
//  rxd         in   1       asynchronous serial line, idle = 1
//  ack         in   1       consumer accepts data_out; clears data_valid
//  data_out    out  DATA_W  last accepted word
//  data_valid  out  1       data_out holds an unacknowledged word
//  parity_err  out  1       parity error on the word in data_out; valid while data_valid=1
//  frame_err   out  1       1-cycle pulse when a stop bit samples 0
//  overrun     out  1       a frame completed while data_valid=1; sticky until ack
//  busy        out  1       FSM is not in IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): both sync flops=1; FSM=IDLE; counters=0.
//   data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
//  Sync: s = rxd delayed by 2 clk. All decisions use s only.
//  FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
//   IDLE:      s==0 -> START, cnt=0. Call this cycle T0.
//   START:     sample at T0+HALF. s==0 -> DATA, bit idx=0, cnt=0. s==1 -> IDLE (glitch, nothing reported).
//   DATA:      bit i sampled at T0+HALF+(i+1)*CLKS_PER_BIT, shifted in LSB first.
//              After bit DATA_W-1 -> PARITY if PARITY_EN, else -> STOP.
//   PARITY:    sampled one CLKS_PER_BIT after the last data bit.
//              perr = ^{data,pbit} (even parity over data plus parity bit).
//   STOP:      sampled CLKS_PER_BIT after the previous sample.
//              s==1 -> deliver the word (see below), then -> IDLE.
//              s==0 -> frame_err=1 for the next cycle, word discarded, -> WAIT_IDLE.
//   WAIT_IDLE: stay until s==1, then -> IDLE. A line held low (break) is reported only once.
//  Deliver (registered, the cycle after the stop sample):
//   - data_valid==0, or ack==1 in the same cycle: load data_out and parity_err, set data_valid=1.
//   - data_valid==1 and ack==0: word discarded, overrun=1. data_out and parity_err unchanged.
//  Handshake:
//   - ack with data_valid=1 clears data_valid and overrun on the next edge.
//   - ack while data_valid=0 is ignored.
//   - data_out holds its value after ack until the next delivery.
//  Latency (IDLE detect at T0): data_valid rises at T0+HALF+(DATA_W+PARITY_EN+1)*CLKS_PER_BIT+1.
//   This is 2 cycles more, counted from the rxd falling edge at the pin.
//  Back-to-back frames: a new start bit is accepted on the first cycle back in IDLE.
//   No extra idle bit is required.
//  Counter widths: $clog2(CLKS_PER_BIT) for the bit timer, $clog2(DATA_W+1) for the bit index.
//   Both wrap by explicit reload, never by overflow.
//  rst_n asserted mid-frame: frame abandoned; all outputs return to reset values at once.
// TESTING
//  (DATA_W=8, CLKS_PER_BIT=4, PARITY_EN=1, bit period 4 clk)
//  1. Frame 0xA5, parity 0, stop 1 -> data_out=8'hA5, data_valid=1, parity_err=0.
//     data_valid rises exactly T0+43 (T0+2+10*4+1).
//  2. Frame 0x01, parity 0 (wrong) -> data_out=8'h01, data_valid=1, parity_err=1.
//  3. Frame 0x3C, stop bit 0, rxd held 0 for 40 clk -> one frame_err pulse, data_valid stays 0.
//     busy=1 until s returns high; then a 0x55 frame is received correctly.
//  4. rxd low for 1 clk, then high -> START aborts to IDLE; no data_valid, no frame_err.
//  5. Frames 0x11 then 0x22 with ack=0 -> data_out=8'h11, overrun=1.
//     ack pulse -> data_valid=0, overrun=0 next cycle.
//  6. rst_n low during DATA bit 4 of 0xFF -> all outputs 0 asynchronously.
//     After release, a 0x81 frame gives data_out=8'h81.

Source files
------------

// File: rtl/serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_rx
// Purpose  : Serial frame receiver. The asynchronous line rxd (idle high) is
//            passed through a 2-flop synchronizer. Start/data/parity/stop
//            frames are then deserialized (data LSB first) and each word is
//            presented in a holding register with a valid/ack handshake.
// Ports    : clk        - rising-edge clock
//            rst_n      - asynchronous active-low reset
//            rxd        - asynchronous serial line, idle = 1
//            ack        - consumer accepts data_out, clears data_valid
//            data_out   - last accepted word
//            data_valid - data_out holds an unacknowledged word
//            parity_err - even-parity error on the word in data_out
//            frame_err  - 1-cycle pulse when a stop bit samples 0
//            overrun    - a frame completed while data_valid=1 (sticky to ack)
//            busy       - receiver FSM is not idle
// Revision : 1.0 - initial release
// ============================================================================
module serial_frame_rx #(
    parameter int DATA_W       = 8,  // data bits per frame, >= 2
    parameter int CLKS_PER_BIT = 4,  // clk cycles per serial bit, >= 4
    parameter int PARITY_EN    = 1   // 1: even parity bit after the data
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rxd,
    input  logic              ack,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int c_half  = CLKS_PER_BIT / 2;
    localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam int c_idx_w = $clog2(DATA_W + 1);

    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(c_half - 1);
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_sync1;
    logic                r_sync2;
    logic                w_s;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_idx_w-1:0]  r_idx;
    logic [DATA_W-1:0]   r_shift;
    logic                r_perr_calc;
    logic                w_cnt_done;
    logic                w_deliver;
    logic                w_frame_bad;
    logic [DATA_W-1:0]   r_data_out;
    logic                r_data_valid;
    logic                r_parity_err;
    logic                r_frame_err;
    logic                r_overrun;

    // ------------------------------------------------------------------
    // Two-flop synchronizer; both flops reset to the idle line level so
    // reset release never looks like a start bit.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;

    // The start bit is checked half a bit after detection; every later
    // sample is one full bit period after the previous one.
    assign w_cnt_done = (r_state == ST_START) ? (r_cnt == c_half_last)
                                              : (r_cnt == c_bit_last);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and per-cycle strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_deliver    = 1'b0;
        w_frame_bad  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_s) begin
                    w_next_state = ST_START;
                end
            end
            ST_START: begin
                if (w_cnt_done) begin
                    // A line that is high again mid start bit was a glitch.
                    w_next_state = w_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_cnt_done && (r_idx == c_idx_last)) begin
                    w_next_state = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (w_cnt_done) begin
                    w_next_state = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_cnt_done) begin
                    if (w_s) begin
                        w_deliver    = 1'b1;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_frame_bad  = 1'b1;
                        w_next_state = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                // A held-low line (break) is reported once, then ignored
                // until the line returns to idle.
                if (w_s) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bit timer, bit index, shift register and parity capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_perr_calc <= 1'b0;
        end else begin
            case (r_state)
                ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
                    r_cnt <= w_cnt_done ? '0 : r_cnt + 1'b1;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase

            if (r_state == ST_DATA) begin
                if (w_cnt_done) begin
                    r_shift <= {w_s, r_shift[DATA_W-1:1]};
                    r_idx   <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
                end
            end else begin
                r_idx <= '0;
            end

            // Even parity: XOR of data plus parity bit must be zero.
            if ((r_state == ST_PARITY) && w_cnt_done) begin
                r_perr_calc <= ^{r_shift, w_s};
            end
        end
    end

    // ------------------------------------------------------------------
    // Holding register and handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err <= w_frame_bad;
            if (w_deliver) begin
                // An ack arriving with the new word frees the register in
                // time, so the word is taken instead of counted as overrun.
                if (!r_data_valid || ack) begin
                    r_data_out   <= r_shift;
                    r_parity_err <= (PARITY_EN != 0) ? r_perr_calc : 1'b0;
                    r_data_valid <= 1'b1;
                    r_overrun    <= 1'b0;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (ack && r_data_valid) begin
                r_data_valid <= 1'b0;
                r_overrun    <= 1'b0;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_frame_rx
// Purpose  : Self-checking bench for serial_frame_rx (8 data bits, 4 clk per
//            bit, even parity). Frames are driven at the pin; the expected
//            outcome of each frame (word or frame error, with its arrival
//            cycle) is queued when the frame starts, and a monitor pops and
//            compares whenever the receiver reports something.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_frame_rx;

    localparam int c_cpb = 4;
    // Pin falling edge to data_valid/frame_err: 2 sync + 2 half bit
    // + 10 bit periods + 1 register stage.
    localparam int c_lat = 2 + 2 + 10 * c_cpb + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       ack_auto = 1'b0;
    logic       ack_man = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit auto_ack = 1'b1;
    logic prev_v = 1'b0;

    typedef struct {
        bit         ferr;
        logic [7:0] d;
        bit         perr;
        int         t;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    serial_frame_rx #(
        .DATA_W       (8),
        .CLKS_PER_BIT (c_cpb),
        .PARITY_EN    (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .ack        (ack_auto | ack_man),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives start, 8 data bits LSB first, parity, stop. When the stop bit
    // is 0 the line is left low for the caller to release.
    task automatic send_frame(input logic [7:0] d, input bit par_ok,
                              input bit stop_ok, input bit expect_word);
        logic [10:0] bits;
        logic        pbit;
        exp_t        e;
        pbit   = par_ok ? (^d) : ~(^d);
        bits   = {stop_ok, pbit, d, 1'b0};
        e.ferr = !stop_ok;
        e.d    = d;
        e.perr = !par_ok;
        e.t    = cyc + c_lat;
        if (!stop_ok || expect_word) q.push_back(e);
        for (int i = 0; i < 11; i++) begin
            rxd = bits[i];
            tick(c_cpb);
        end
    endtask

    task automatic drain(input bit need_idle);
        int n;
        n = 0;
        while ((q.size() != 0 || (need_idle && data_valid)) && n < 500) begin
            tick(1);
            n++;
        end
        check("drain_timeout", n < 500, 1);
    endtask

    // Monitor: every reported event must match the head of the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (frame_err) begin
                    check("queue_nonempty_on_frame_err", q.size() > 0, 1);
                    if (q.size() > 0) begin
                        mon_e = q.pop_front();
                        check("event_is_frame_err", mon_e.ferr, 1);
                        check("frame_err_cycle", cyc, mon_e.t);
                    end
                end
                if (data_valid && !prev_v) begin
                    check("queue_nonempty_on_valid", q.size() > 0, 1);
                    if (q.size() > 0) begin
                        mon_e = q.pop_front();
                        check("event_is_word", mon_e.ferr, 0);
                        check("data_out", data_out, mon_e.d);
                        check("parity_err", parity_err, mon_e.perr);
                        check("valid_cycle", cyc, mon_e.t);
                        check("overrun_on_delivery", overrun, 0);
                    end
                end
            end
            prev_v = data_valid;
        end
    end

    // Consumer: acknowledges each word after a short random delay.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_ack && data_valid && rst_n) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                @(posedge clk);
                #1 ack_auto = 1'b1;
                @(posedge clk);
                #1 ack_auto = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        int         kind;

        rst_n = 1'b0;
        rxd   = 1'b1;
        tick(3);
        check("reset_data_out", data_out, 0);
        check("reset_data_valid", data_valid, 0);
        check("reset_parity_err", parity_err, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;
        tick(3);

        // Good frame, then a frame with wrong parity.
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
        tick(8);
        send_frame(8'h01, 1'b0, 1'b1, 1'b1);
        drain(1);
        tick(4);

        // Stop bit 0 with the line held low: one frame error, busy until idle.
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        tick(10);
        check("break_busy", busy, 1);
        check("break_no_valid", data_valid, 0);
        tick(22);
        rxd = 1'b1;
        tick(1);
        check("break_busy_until_s_high", busy, 1);
        tick(4);
        check("break_released_idle", busy, 0);
        send_frame(8'h55, 1'b1, 1'b1, 1'b1);
        drain(1);

        // Single-cycle glitch aborts in START.
        rxd = 1'b0;
        tick(1);
        rxd = 1'b1;
        tick(3);
        check("glitch_busy", busy, 1);
        tick(6);
        check("glitch_back_idle", busy, 0);
        check("glitch_no_valid", data_valid, 0);

        // Overrun: two words without ack.
        auto_ack = 1'b0;
        send_frame(8'h11, 1'b1, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1, 1'b0);
        tick(6);
        drain(0);
        check("overrun_data_out", data_out, 8'h11);
        check("overrun_valid", data_valid, 1);
        check("overrun_flag", overrun, 1);
        ack_man = 1'b1;
        tick(1);
        ack_man = 1'b0;
        check("ack_clears_valid", data_valid, 0);
        check("ack_clears_overrun", overrun, 0);
        check("data_out_held_after_ack", data_out, 8'h11);

        // Async reset during data bit 4 of 0xFF, with a word still held.
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1);
        tick(4);
        check("held_word_valid", data_valid, 1);
        rxd = 1'b0;
        tick(c_cpb);
        for (int i = 0; i < 4; i++) begin
            rxd = 1'b1;
            tick(c_cpb);
        end
        tick(2);
        check("mid_frame_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_data_out", data_out, 0);
        check("async_rst_valid", data_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_overrun", overrun, 0);
        check("async_rst_parity_err", parity_err, 0);
        rxd = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        auto_ack = 1'b1;
        send_frame(8'h81, 1'b1, 1'b1, 1'b1);
        drain(1);

        // Randomized traffic: good/bad parity, breaks, glitches, gaps.
        for (int k = 0; k < 40; k++) begin
            d    = 8'($urandom);
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                rxd = 1'b0;
                tick(1);
                rxd = 1'b1;
                tick(4);
            end else if (kind == 1) begin
                send_frame(d, 1'b1, 1'b0, 1'b0);
                tick($urandom_range(0, 30));
                rxd = 1'b1;
                tick($urandom_range(1, 8));
            end else begin
                send_frame(d, $urandom_range(0, 3) != 0, 1'b1, 1'b1);
                tick($urandom_range(0, 6));
            end
        end
        drain(1);
        tick(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
